// File: rtl/alu_result_if.sv
// Bus bundle between the ALU result producer and the result buffer.
// The slave side is the buffer and the master side is the ALU/writeback environment.
interface alu_result_if;
  logic        in_valid;
  logic [73:0] in_packet;
  logic        in_ready;
  logic        out_ready;
  logic        out_valid;
  logic [2:0]  out_type;
  logic [31:0] out_result;
  logic [31:0] out_addr;
  logic [4:0]  out_aux;
  logic        out_redirect;
  logic        out_trap;

  modport slave (
    input  in_valid, in_packet, out_ready,
    output in_ready, out_valid, out_type, out_result, out_addr, out_aux,
           out_redirect, out_trap
  );

  modport master (
    output in_valid, in_packet, out_ready,
    input  in_ready, out_valid, out_type, out_result, out_addr, out_aux,
           out_redirect, out_trap
  );
endinterface

// File: rtl/alu_result_buffer.sv
// Small FIFO that receives ALU result packets and presents decoded head fields
// to the writeback/memory stage through a valid/ready handshake.
module alu_result_buffer #(
  parameter int DEPTH = 2,
  parameter int PTR_W = 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  alu_result_if.slave      bus,
  input  logic             flush,
  output logic [PTR_W:0]   count,
  output logic             overflow
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [73:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             push, pop, in_ready, out_valid;
  logic [73:0]      head;

  assign in_ready  = (count_q != FULL_CNT);
  assign out_valid = (count_q != '0);
  assign push      = bus.in_valid & in_ready & ~flush;
  assign pop       = out_valid & bus.out_ready & ~flush;

  // Flush wins over everything; a packet offered alongside it is simply discarded.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (bus.in_valid & ~in_ready & ~flush);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage holds data only; its contents are meaningless until written.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= bus.in_packet;
  end

  assign head = out_valid ? mem_q[rd_ptr_q] : '0;

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = out_valid;
  assign bus.out_type     = head[73:71];
  assign bus.out_result   = head[70:39];
  assign bus.out_addr     = head[38:7];
  assign bus.out_aux      = head[6:2];
  assign bus.out_redirect = head[1];
  assign bus.out_trap     = head[0];
  assign count            = count_q;
  assign overflow         = overflow_q;

endmodule

// File: doc/alu_result_buffer.md
Name: alu_result_buffer

Overview:
- Receiving end of the ALU result interface: accepts 74-bit result packets from the ALU stage (valid = ALU RDY_inputs, packet = ALU result bus).
- Buffers packets in a small FIFO, decodes fields for the writeback/memory stage, and hands them off through a valid/ready handshake.
- Provides flush for pipeline redirect, plus occupancy and sticky overflow status.

Parameters:
DEPTH, 2, FIFO entries; power of two, >= 2
PTR_W, 1, pointer width = log2(DEPTH)

Ports:
CLK  input  1  clock, rising edge
RST_N  input  1  reset, asynchronous, active-low
in_valid  input  1  ALU packet valid (connects to ALU RDY_inputs)
in_packet  input  74  ALU result packet
in_ready  output  1  buffer can accept this cycle
out_ready  input  1  downstream consumes head this cycle
out_valid  output  1  head entry present
out_type  output  3  head packet[73:71], commit type
out_result  output  32  head packet[70:39], ALU result
out_addr  output  32  head packet[38:7], effective address / redirect PC
out_aux  output  5  head packet[6:2], funct3/memaccess side info
out_redirect  output  1  head packet[1]
out_trap  output  1  head packet[0]
flush  input  1  synchronous discard of all entries
count  output  PTR_W+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: valid packet offered while full

Behaviour:
- Reset (RST_N low, asynchronous): wr_ptr=0, rd_ptr=0, count=0, overflow=0; out_valid=0 and all decoded outputs 0; in_ready=1 after reset release. Storage array is not reset.
- in_ready = (count != DEPTH), combinational from registered count only; no dependency on out_ready, so there is no full-state pass-through.
- push = in_valid & in_ready & ~flush: writes in_packet at wr_ptr, wr_ptr increments modulo DEPTH.
- pop = out_valid & out_ready & ~flush: rd_ptr increments modulo DEPTH.
- count update:
  - push only: +1
  - pop only: -1
  - both or neither: unchanged
- Latency: a packet pushed at edge N is visible at the outputs after edge N with out_valid=1. There is no same-cycle bypass from an empty buffer.
- out_valid = (count != 0).
- Decoded outputs are combinational slices of the storage entry at rd_ptr when out_valid=1. They are forced to 0 when out_valid=0.
- Ordering is strict FIFO. Pointers wrap at DEPTH-1 -> 0.
- Full with simultaneous in_valid and pop: in_ready=0, so no push. count goes DEPTH -> DEPTH-1. The offered packet is dropped and overflow is set.
- Overflow: set on any edge where in_valid & ~in_ready & ~flush. Cleared only by reset; flush does not clear it.
- Flush (priority over push/pop): at the edge, wr_ptr=rd_ptr=0 and count=0. Any concurrent in_valid packet is discarded; no overflow is set by it. out_valid=0 the following cycle.
- Empty with out_ready=1: no pop, no state change.
- Reset asserted mid-operation: all state clears immediately regardless of CLK. Buffered packets are lost.

Test Plan:
- Reset then idle: RST_N low 3 cycles, release -> count=0, out_valid=0, in_ready=1, overflow=0, out_result=0.
- Single packet: in_packet with type=3'b010, result=32'hDEADBEEF, addr=32'h0000_1000, aux=5'h05, redirect=1, trap=0, pushed at edge 1 with out_ready=0 -> after edge 1 out_valid=1, all fields decode exactly, count=1; out_ready=1 at edge 2 -> out_valid=0, count=0.
- Fill and overflow: push results 32'h1, 32'h2 with out_ready=0 -> count=2, in_ready=0; offer 32'h3 -> dropped, overflow=1; then pop 3 times -> sequence 32'h1, 32'h2, then out_valid=0; overflow remains 1.
- Full with simultaneous offer and pop: count=2, in_valid=1 (32'h9), out_ready=1 -> count=1, 32'h9 not stored, overflow=1. Next cycle push 32'hA and pop together -> count stays 1, head=32'hA after.
- Streaming wrap: in_valid=1 and out_ready=1 continuously for 10 packets 32'h10..32'h19 -> outputs in order, count never exceeds 1, pointers wrap cleanly, no overflow.
- Flush and async reset: with count=2, assert flush together with in_valid (32'h55) -> count=0, out_valid=0, overflow unchanged, 32'h55 absent. Refill to 1 entry, then pulse RST_N low between clock edges -> count=0 and out_valid=0 immediately.
